// File: rtl/multi_clk_div.sv
// Multi-channel programmable clock divider: each channel divides clk_in by a
// run-time loadable divisor, with glitch-free updates at period boundaries and a shared sync.
module multi_clk_div #(
  parameter int CHANNELS    = 2,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 100
) (
  input  logic                      clk_in,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*CNT_W-1:0] div_val,
  input  logic [CHANNELS-1:0]       load,
  input  logic                      sync,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       pend
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] pend_div_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pend_q;
    logic             clk_q;
    logic             tick_q;

    logic [CNT_W-1:0] load_div;
    logic [CNT_W-1:0] eff_div;
    logic [CNT_W-1:0] next_cnt;
    logic [CNT_W-1:0] high_time;
    logic             boundary;

    // Divisors below 2 cannot form a high and a low phase, so they are clamped to 2.
    always_comb begin
      load_div  = div_val[i*CNT_W +: CNT_W];
      if (load_div < TWO) begin
        load_div = TWO;
      end
      eff_div   = pend_q ? pend_div_q : div_q;
      boundary  = sync || (cnt_q == div_q - ONE);
      next_cnt  = cnt_q + ONE;
      high_time = div_q - (div_q >> 1);
    end

    always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
        div_q      <= CNT_W'(DEFAULT_DIV);
        pend_div_q <= '0;
        pend_q     <= 1'b0;
        cnt_q      <= CNT_W'(DEFAULT_DIV - 1);
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        if (!en[i]) begin
          // Parking at D-1 makes the first enabled edge a natural period boundary.
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
          if (pend_q) begin
            div_q  <= pend_div_q;
            cnt_q  <= pend_div_q - ONE;
            pend_q <= 1'b0;
          end else begin
            cnt_q <= div_q - ONE;
          end
        end else if (boundary) begin
          div_q  <= eff_div;
          pend_q <= 1'b0;
          cnt_q  <= '0;
          clk_q  <= 1'b1;
          tick_q <= 1'b1;
        end else begin
          cnt_q  <= next_cnt;
          clk_q  <= (next_cnt < high_time);
          tick_q <= 1'b0;
        end
        // A load always lands in the pending slot, so it waits for the next boundary.
        if (load[i]) begin
          pend_div_q <= load_div;
          pend_q     <= 1'b1;
        end
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
    assign pend[i]    = pend_q;
  end

endmodule

// File: doc/multi_clk_div.md
# multi_clk_div

Multi-channel programmable clock divider. It is the parametrised successor to the fixed single-divisor divider. Each of `CHANNELS` outputs derives a divided clock from one 10 MHz source. Divisors are loaded at run time and take effect glitch-free at a period boundary. Odd divisors are supported, and a common sync input phase-aligns all channels. It feeds the sensor-sampling, display-scan and UART baud-generation logic.

## Interface
- `CHANNELS`, 2, number of independent divider channels (1..8)
- `CNT_W`, 16, counter and divisor width in bits
- `DEFAULT_DIV`, 100, divisor loaded into every channel at reset (2..2^CNT_W-1)

- `clk_in` in 1: source clock; all logic on rising edge
- `rst` in 1: asynchronous, active-high reset
- `en` in CHANNELS: per-channel run enable, level
- `div_val` in CHANNELS*CNT_W: per-channel divisor; channel i uses bits [i*CNT_W +: CNT_W]
- `load` in CHANNELS: one-cycle strobe that captures `div_val` slice i into channel i's pending register
- `sync` in 1: one-cycle strobe that restarts every enabled channel at period start
- `clk_out` out CHANNELS: divided clock, registered
- `tick` out CHANNELS: one-cycle pulse in the cycle `clk_out[i]` rises
- `pend` out CHANNELS: high while a loaded divisor is waiting to be applied

## Operation
- Per-channel state:
  - active divisor D, reset DEFAULT_DIV
  - pending divisor P and flag `pend`, reset 0
  - counter `cnt`, reset DEFAULT_DIV-1
  - `clk_out` and `tick`, reset 0
- Divisor clamp: a loaded value of 0 or 1 is stored as 2. The maximum divisor is 2^CNT_W-1.
- High time H = D - floor(D/2), i.e. ceil(D/2); low time = floor(D/2). Odd D gives one extra high cycle (D=5: 3 high, 2 low).
- Enabled, no sync:
  - When `cnt`==D-1 the channel is at the period boundary: `cnt` goes to 0.
  - Otherwise `cnt` goes to `cnt`+1.
  - `clk_out` gets (next `cnt` < H).
  - `tick` gets 1 exactly when next `cnt` is 0.
- Period boundary with `pend`=1: D takes the value P before the wrap computation, so the new period already uses the new D and H. `pend` clears.
- `en`=0:
  - `cnt` is held at D-1; `clk_out` and `tick` are 0.
  - If `pend`=1, D takes P immediately, `cnt` is set to P-1 and `pend` clears.
- Enable rise: the first enabled edge wraps `cnt` to 0 with `clk_out`=1 and `tick`=1. No partial first period.
- `sync`=1: every enabled channel behaves as at a boundary. A pending divisor is applied, `cnt` goes to 0, `clk_out` to 1 and `tick` to 1, regardless of current phase. Disabled channels ignore `sync`.
- `load` handling:
  - A `load` in the same cycle as a boundary or `sync` is not applied at that boundary. P is written, `pend` becomes 1, and it is applied at the next boundary.
  - A `load` while `pend`=1 overwrites P; the last value wins.
- Channels are fully independent apart from the shared `sync`.
- `rst` mid-operation: all state returns to reset values immediately (asynchronously). Pending loads are discarded.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Output period is D `clk_in` cycles. At D=2, `clk_out` toggles every cycle (5 MHz from 10 MHz).
- `load` to `pend`=1: one cycle.
- Disabled channel: the new D is active one cycle after `load`.
- Enabled channel: the new D is active at the first boundary strictly after the `load` cycle, at most D_old cycles later.
- `en` rise to first `clk_out`/`tick` high: one cycle. `en` fall to `clk_out`=0: one cycle. `clk_out` may truncate a high phase on disable; this is accepted.
- `sync` to aligned `clk_out` rising on all enabled channels: one cycle, the same edge on every channel.
- After `rst` deasserts, `clk_out` stays 0 until `en` is high.

## Test plan
- Reset, then `en`=1 with DEFAULT_DIV=100: `clk_out` rises on the first edge, stays high 50 cycles and low 50 cycles, with `tick` every 100 cycles.
- Load D=5 on a disabled channel, then enable: `pend` is high 1 cycle, then the pattern repeats 3 high, 2 low, and `tick` spacing is 5.
- Channel running at D=10; load D=4 at `cnt`=3: `pend` stays high until the wrap 6 cycles later, then periods are 4 cycles (2 high/2 low) with no short or long pulse.
- Two channels at D=6 and D=9, out of phase; pulse `sync`: both `clk_out` and `tick` rise on the same next edge.
- Load 0 and 1: the stored D is 2 in both cases, and `clk_out` toggles every cycle. A load coincident with a boundary is applied one period later.
- Assert `rst` mid-high-phase at D=8: `clk_out`, `tick` and `pend` go to 0 immediately. After release with `en`=1, the output runs at D=100 again.
